// File: rtl/router_pkg.sv
// Shared router definitions: port counts, select width and allocator state encoding.
package router_pkg;
  localparam int NODE_PER_ROW = 4;
  localparam int NODE_PER_COL = 4;
  localparam int NUM_PORT     = NODE_PER_ROW + NODE_PER_COL - 1;
  localparam int SEL_W        = $clog2(NUM_PORT);
  localparam int LOCAL_PORT   = NUM_PORT - 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;
endpackage

// File: rtl/rr_lock_arbiter.sv
// One output's round-robin arbiter with wormhole lock; grant is combinational (0 cycles)
// and is only issued when ready=1, so a stalled output changes no state.
module rr_lock_arbiter
  import router_pkg::*;
#(
  parameter int N = NUM_PORT,
  parameter int W = SEL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:N-1] req,
  input  logic [0:N-1] tail,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] sel
);

  alloc_state_e r_state;
  logic [W-1:0] r_rr_ptr;
  logic [W-1:0] r_owner;

  logic         w_found;
  logic [W-1:0] w_winner;
  logic [W-1:0] w_next_ptr;
  logic         w_valid;
  logic [W-1:0] w_sel;
  int           w_idx;

  // Search starts at r_rr_ptr and wraps at N, so index N is never produced.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = W'(w_idx);
      end
    end
    w_next_ptr = (int'(w_winner) == N - 1) ? '0 : w_winner + W'(1);
  end

  always_comb begin
    w_valid = 1'b0;
    w_sel   = '0;
    case (r_state)
      ST_IDLE: begin
        w_valid = w_found & ready;
        w_sel   = w_winner;
      end
      ST_LOCKED: begin
        w_valid = req[r_owner] & ready;
        w_sel   = r_owner;
      end
      default: begin
        w_valid = 1'b0;
        w_sel   = '0;
      end
    endcase
  end

  assign valid = w_valid & ~rst;
  assign sel   = valid ? w_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_rr_ptr <= w_next_ptr;
            if (!tail[w_winner]) begin
              r_state <= ST_LOCKED;
              r_owner <= w_winner;
            end
          end
        end
        ST_LOCKED: begin
          if (w_valid && tail[r_owner]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Router output-port allocator: one rr_lock_arbiter per output, grants in the same cycle;
// an output without credit (out_ready=0) grants nothing and holds its state.
module switch_allocator
  import router_pkg::*;
#(
  parameter int NODE_PER_ROW_P = NODE_PER_ROW,
  parameter int NODE_PER_COL_P = NODE_PER_COL,
  parameter int NP             = NODE_PER_ROW_P + NODE_PER_COL_P - 1,
  parameter int SW             = $clog2(NP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:NP*NP-1] req_vec,
  input  logic [0:NP-1]    tail_i,
  input  logic [0:NP-1]    out_ready,
  output logic [0:NP-1]    in_grant,
  output logic [0:NP-1]    out_valid,
  output logic [0:NP*SW-1] out_sel
);

  logic [0:NP-1] w_col [NP];
  logic [SW-1:0] w_sel [NP];

  genvar gi, gj;
  generate
    for (gj = 0; gj < NP; gj++) begin : g_out
      for (gi = 0; gi < NP; gi++) begin : g_col
        assign w_col[gj][gi] = req_vec[gi*NP + gj];
      end

      rr_lock_arbiter #(.N(NP), .W(SW)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_col[gj]),
        .tail  (tail_i),
        .ready (out_ready[gj]),
        .valid (out_valid[gj]),
        .sel   (w_sel[gj])
      );

      assign out_sel[gj*SW +: SW] = w_sel[gj];
    end

    for (gi = 0; gi < NP; gi++) begin : g_chk
      a_row_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_vec[gi*NP +: NP]));
    end
  endgenerate

  always_comb begin
    in_grant = '0;
    for (int j = 0; j < NP; j++) begin
      if (out_valid[j]) in_grant[w_sel[j]] = 1'b1;
    end
  end

endmodule
